// File: rtl/pwm_pkg.sv
// Shared widths, default limits and FSM state type for the PWM pulse generator.
package pwm_pkg;
  localparam int US_W       = 12;
  localparam int FRAME_W    = 15;
  localparam int DEF_MIN_US = 900;
  localparam int DEF_MAX_US = 2000;
  localparam int IDLE_US    = DEF_MIN_US;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pwm_state_t;

  function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] value,
                                               input logic [US_W-1:0] lo,
                                               input logic [US_W-1:0] hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction
endpackage

// File: rtl/pwm_pulse_gen_if.sv
// Command side (pulse width, arm) and waveform side (PWM pin, frame status) of one motor output.
interface pwm_pulse_gen_if;
  import pwm_pkg::*;

  logic [US_W-1:0] pulse_time;
  logic            enable;
  logic            pwm_out;
  logic            frame_start;
  logic [US_W-1:0] active_time;

  modport master (output pulse_time, enable, input pwm_out, frame_start, active_time);
  modport slave  (input pulse_time, enable, output pwm_out, frame_start, active_time);
endinterface

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: us_tick is high on the last clock of every CLK_DIV_US-clock period.
module us_tick_gen #(
  parameter int CLK_DIV_US = 27
) (
  input  logic clock,
  input  logic reset,
  output logic us_tick
);
  localparam int CNT_W = (CLK_DIV_US > 1) ? $clog2(CLK_DIV_US) : 1;

  logic [CNT_W-1:0] count;

  assign us_tick = (count == CNT_W'(CLK_DIV_US - 1));

  always_ff @(posedge clock) begin
    if (reset || us_tick) count <= '0;
    else                  count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/pwm_pulse_gen.sv
// PWM frame generator: one pulse of the latched width per FRAME_US frame.
// Build option PWM_SLEW_LIMIT_EN limits per-frame width increases to SLEW_US.
//
// state | meaning
// LOW   | output low; waiting for the next frame boundary
// HIGH  | pulse in progress; ends after active_time microseconds
module pwm_pulse_gen
  import pwm_pkg::*;
#(
  parameter int CLK_DIV_US = 27,
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = IDLE_US,
  parameter int MAX_US     = DEF_MAX_US,
  parameter int SLEW_US    = 16
) (
  input  logic           clock,
  input  logic           reset,
  pwm_pulse_gen_if.slave bus
);
`ifdef PWM_SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic               us_tick;
  logic               start_q;
  logic               boundary;
  logic               tick_clr;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic [US_W-1:0]    active_time;
  logic [US_W-1:0]    target;
  logic [US_W-1:0]    next_time;
  pwm_state_t         state;

  // start_q marks the first edge after reset as a boundary and holds the prescaler at zero for it
  assign tick_clr = reset | start_q;

  us_tick_gen #(.CLK_DIV_US(CLK_DIV_US)) u_tick (
    .clock   (clock),
    .reset   (tick_clr),
    .us_tick (us_tick)
  );

  assign boundary = start_q | (us_tick & (frame_cnt == FRAME_W'(FRAME_US - 1)));
  assign target   = clamp_us(bus.pulse_time, US_W'(MIN_US), US_W'(MAX_US));

  // Decreases apply at once so a cut to idle is never delayed by the ramp
  always_comb begin
    next_time = target;
    if (SLEW_ON && (int'(target) > int'(active_time) + SLEW_US))
      next_time = active_time + US_W'(SLEW_US);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q     <= 1'b1;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      active_time <= US_W'(MIN_US);
      state       <= LOW;
    end else begin
      start_q     <= 1'b0;
      frame_start <= boundary;
      if (boundary) begin
        frame_cnt   <= '0;
        active_time <= next_time;
        state       <= bus.enable ? HIGH : LOW;
      end else begin
        if (us_tick) frame_cnt <= frame_cnt + FRAME_W'(1);
        if (state == HIGH && us_tick && (frame_cnt + FRAME_W'(1) == FRAME_W'(active_time)))
          state <= LOW;
      end
    end
  end

  assign bus.pwm_out     = (state == HIGH);
  assign bus.frame_start = frame_start;
  assign bus.active_time = active_time;
endmodule
